// File: rtl/conv_pool_unit.sv
// Window consumer: sequential KxK MAC convolution or 2x2 signed max pool, one pixel per window.
// Optional macro CONV_POOL_RELU_EN clamps negative results to zero in both modes.
module conv_pool_unit #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int K      = 5,
  parameter int ACC_W  = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pooling,
  input  logic                  filter_load,
  input  logic [K*K*DATA_W-1:0] filter_in,
  input  logic                  window_valid,
  input  logic [K*K*DATA_W-1:0] window_in,
  output logic                  next,
  output logic                  result_valid,
  output logic [DATA_W-1:0]     result,
  output logic                  busy
);

  localparam int TAPS  = K * K;
  localparam int TAP_W = $clog2(TAPS);
  localparam int PRD_W = 2 * DATA_W;
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
  localparam logic [TAP_W-1:0] TAP_ONE  = TAP_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, POOL = 2'd2, DONE = 2'd3} state_e;

  state_e                    state_q, state_d;
  logic [TAP_W-1:0]          tap_q, tap_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0]  result_q, result_d;
  logic signed [DATA_W-1:0]  win_q  [TAPS];
  logic signed [DATA_W-1:0]  filt_q [TAPS];
  logic signed [PRD_W-1:0]   prod_s;
  logic signed [ACC_W-1:0]   prod_ext_s;
  logic signed [DATA_W-1:0]  pool_max_s;

  // Arithmetic shift floors toward -inf; out-of-range values clamp to the signed pixel limits.
  function automatic logic signed [DATA_W-1:0] scale_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC_W;
    if (s > ACC_MAX) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end else if (s < ACC_MIN) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return s[DATA_W-1:0];
    end
  endfunction

  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
`ifdef CONV_POOL_RELU_EN
    return v[DATA_W-1] ? {DATA_W{1'b0}} : v;
`else
    return v;
`endif
  endfunction

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign prod_s     = win_q[tap_q] * filt_q[tap_q];
  assign prod_ext_s = {{(ACC_W-PRD_W){prod_s[PRD_W-1]}}, prod_s};
  assign pool_max_s = smax(smax(win_q[0], win_q[1]), smax(win_q[K], win_q[K+1]));

  assign next         = (state_q == IDLE) & ~rst;
  assign result_valid = (state_q == DONE);
  assign result       = result_q;
  assign busy         = (state_q != IDLE) | (window_valid & next);

  // Next-state, tap sequencing, accumulation and result formation.
  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (window_valid) begin
          if (pooling) begin
            state_d = POOL;
          end else begin
            state_d = MAC;
            tap_d   = {TAP_W{1'b0}};
            acc_d   = {ACC_W{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        acc_d = acc_q + prod_ext_s;
        if (tap_q == TAP_LAST) begin
          state_d  = DONE;
          result_d = relu(scale_sat(acc_d));
        end else begin
          tap_d = tap_q + TAP_ONE;
        end
      end
      POOL: begin
        result_d = relu(pool_max_s);
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tap_q    <= {TAP_W{1'b0}};
      acc_q    <= {ACC_W{1'b0}};
      result_q <= {DATA_W{1'b0}};
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // Filter and window capture happen only in IDLE, so an in-flight window sees stable operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        win_q[i]  <= {DATA_W{1'b0}};
        filt_q[i] <= {DATA_W{1'b0}};
      end
    end else if (state_q == IDLE) begin
      for (int i = 0; i < TAPS; i++) begin
        if (filter_load) begin
          filt_q[i] <= filter_in[i*DATA_W +: DATA_W];
        end
        if (window_valid) begin
          win_q[i] <= window_in[i*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_pool_unit.sv
// Directed bench for conv_pool_unit: vector table plus hand-written multi-cycle sequences.
module tb_conv_pool_unit;

  localparam int DW = 16;
  localparam int K  = 5;
  localparam int WW = K * K * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          pooling;
  logic          filter_load;
  logic [WW-1:0] filter_in;
  logic          window_valid;
  logic [WW-1:0] window_in;
  logic          next;
  logic          result_valid;
  logic [DW-1:0] result;
  logic          busy;

  int tests = 0;
  int fails = 0;

  conv_pool_unit dut (
    .clk(clk), .rst(rst), .pooling(pooling), .filter_load(filter_load),
    .filter_in(filter_in), .window_valid(window_valid), .window_in(window_in),
    .next(next), .result_valid(result_valid), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          pool;
    logic [DW-1:0] f, w, c0, c1, c2, c3, exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] uni(input logic [DW-1:0] v);
    logic [WW-1:0] r;
    for (int i = 0; i < K*K; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [WW-1:0] corners(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                                           input logic [DW-1:0] c2, input logic [DW-1:0] c3,
                                           input logic [DW-1:0] rest);
    logic [WW-1:0] r;
    r = uni(rest);
    r[0*DW +: DW]     = c0;
    r[1*DW +: DW]     = c1;
    r[K*DW +: DW]     = c2;
    r[(K+1)*DW +: DW] = c3;
    return r;
  endfunction

  function automatic logic [WW-1:0] junk();
    logic [WW-1:0] r;
    for (int i = 0; i < K*K; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  function automatic logic [DW-1:0] relu_tb(input logic [DW-1:0] v);
`ifdef CONV_POOL_RELU_EN
    return v[DW-1] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  // Accepts the window already on window_in, then scrambles inputs while waiting for the result.
  task automatic run_win(input string nm, input logic pool_m, input int exp_lat,
                         input logic [DW-1:0] exp_res, input int mid_cyc,
                         input logic [DW-1:0] mid_filt);
    bit seen;
    int lat;
    window_valid = 1'b1;
    pooling      = pool_m;
    @(negedge clk);
    check({nm, "_accept_next"}, {31'd0, next}, 32'd1);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      step();
      window_valid = 1'b0;
      window_in    = junk();
      pooling      = ~pool_m;
      filter_load  = 1'b0;
      if (k == mid_cyc) begin
        filter_in   = uni(mid_filt);
        filter_load = 1'b1;
      end
      @(negedge clk);
      if (k == 1) check({nm, "_busy"}, {31'd0, busy}, 32'd1);
      if (result_valid) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    filter_load = 1'b0;
    check({nm, "_latency"}, lat, exp_lat);
    check({nm, "_result"}, {16'd0, result}, {16'd0, exp_res});
    step();
    @(negedge clk);
    check({nm, "_rv_pulse"}, {31'd0, result_valid}, 32'd0);
    check({nm, "_next_back"}, {31'd0, next}, 32'd1);
    check({nm, "_hold"}, {16'd0, result}, {16'd0, exp_res});
    step();
  endtask

  initial begin
    rst          = 1'b1;
    pooling      = 1'b0;
    filter_load  = 1'b0;
    filter_in    = '0;
    window_valid = 1'b0;
    window_in    = '0;

    vecs[0] = '{1'b0, 16'h0100, 16'h0200, 16'h0, 16'h0, 16'h0, 16'h0, 16'h3200};
    vecs[1] = '{1'b0, 16'h7FFF, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF};
    vecs[2] = '{1'b0, 16'h7FFF, 16'h8001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8000};
    vecs[3] = '{1'b0, 16'h0100, 16'hFF00, 16'h0, 16'h0, 16'h0, 16'h0, 16'hE700};
    vecs[4] = '{1'b0, 16'h0080, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h000C};
    vecs[5] = '{1'b0, 16'h0080, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFF3};
    vecs[6] = '{1'b1, 16'h0000, 16'h0000, 16'hFD00, 16'h0700, 16'h0200, 16'hF800, 16'h0700};
    vecs[7] = '{1'b1, 16'h0000, 16'h0000, 16'hFF00, 16'hFE00, 16'hFC00, 16'hF800, 16'hFF00};
    vecs[8] = '{1'b1, 16'h0000, 16'h7FFF, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0004};

    // Reset and idle
    @(negedge clk);
    check("rst_next_low", {31'd0, next}, 32'd0);
    step();
    @(negedge clk);
    check("rst_next_low2", {31'd0, next}, 32'd0);
    step();
    rst = 1'b0;
    step(); step(); step();
    @(negedge clk);
    check("idle_next", {31'd0, next}, 32'd1);
    check("idle_rv", {31'd0, result_valid}, 32'd0);
    check("idle_result", {16'd0, result}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    step();

    // Table-driven windows
    for (int i = 0; i < 9; i++) begin
      if (!vecs[i].pool) begin
        filter_in   = uni(vecs[i].f);
        filter_load = 1'b1;
        step();
        filter_load = 1'b0;
        window_in   = uni(vecs[i].w);
      end else begin
        window_in = corners(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3, vecs[i].w);
      end
      run_win($sformatf("vec%0d", i), vecs[i].pool, vecs[i].pool ? 2 : 26,
              relu_tb(vecs[i].exp), -1, 16'h0000);
    end

    // Pool with window_valid held high: re-accept on cycle 3
    window_in    = corners(16'hFD00, 16'h0700, 16'h0200, 16'hF800, 16'h0000);
    pooling      = 1'b1;
    window_valid = 1'b1;
    @(negedge clk);
    check("pb2b_c0_next", {31'd0, next}, 32'd1);
    step();
    @(negedge clk);
    check("pb2b_c1_next", {31'd0, next}, 32'd0);
    step();
    @(negedge clk);
    check("pb2b_c2_rv", {31'd0, result_valid}, 32'd1);
    check("pb2b_c2_res", {16'd0, result}, 32'h0000_0700);
    step();
    @(negedge clk);
    check("pb2b_c3_next", {31'd0, next}, 32'd1);
    step();
    window_valid = 1'b0;
    step();
    @(negedge clk);
    check("pb2b_c5_rv", {31'd0, result_valid}, 32'd1);
    step();
    step();

    // Filter change mid-MAC is ignored; load with accept takes effect
    filter_in   = uni(16'h0100);
    filter_load = 1'b1;
    step();
    filter_load = 1'b0;
    window_in   = uni(16'h0200);
    run_win("midload", 1'b0, 26, 16'h3200, 10, 16'h0200);
    filter_in   = uni(16'h0200);
    filter_load = 1'b1;
    window_in   = uni(16'h0200);
    run_win("loadacc", 1'b0, 26, 16'h6400, -1, 16'h0000);

    // Reset at MAC cycle 12 aborts with no result, clears filter
    filter_in   = uni(16'h0100);
    filter_load = 1'b1;
    step();
    filter_load  = 1'b0;
    window_in    = uni(16'h0200);
    pooling      = 1'b0;
    window_valid = 1'b1;
    step();
    window_valid = 1'b0;
    for (int k = 1; k < 12; k++) step();
    rst = 1'b1;
    @(negedge clk);
    check("abort_next_in_rst", {31'd0, next}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("abort_next_after", {31'd0, next}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    begin
      int rv_seen = 0;
      for (int k = 0; k < 20; k++) begin
        step();
        @(negedge clk);
        if (result_valid) rv_seen++;
      end
      check("abort_no_rv", rv_seen, 0);
    end
    step();
    window_in = uni(16'h0200);
    run_win("cleared_filter", 1'b0, 26, 16'h0000, -1, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
